// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - shared opcodes, FSM states and operand addresses for alu_cmd_ctrl
package alu_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR_DEF = 0;
  localparam int OPB_ADDR_DEF = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    ALU_A,
    ALU_B,
    ALU_FUN,
    ALU_WAIT,
    TX_BYTE0,
    TX_BYTE1
  } state_t;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - byte-framed command sequencer driving register file, ALU and TX FIFO
module alu_cmd_ctrl
  import alu_cmd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ALU_OUT_W = 16,
  parameter int ADDR_W    = 4,
  parameter int OPA_ADDR  = OPA_ADDR_DEF,
  parameter int OPB_ADDR  = OPB_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic [ALU_OUT_W-1:0] alu_out,
  input  logic                 alu_out_valid,
  output logic [3:0]           alu_fun,
  output logic                 alu_en,
  output logic                 clk_gate_en,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic                 rf_wr_en,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic                 rf_rd_en,
  input  logic [DATA_W-1:0]    rf_rd_data,
  input  logic                 rf_rd_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 fifo_full
);

  state_t                r_state;
  logic [ALU_OUT_W-1:0]  r_result;
  logic                  r_is_alu;
  logic [ADDR_W-1:0]     r_addr;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_is_alu    <= 1'b0;
      r_addr      <= '0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
      rf_addr     <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_data  <= '0;
      rf_rd_en    <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      tx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data[7:0])
              CMD_RF_WR:  r_state <= WR_ADDR;
              CMD_RF_RD:  r_state <= RD_ADDR;
              CMD_ALU_OP: r_state <= ALU_A;
              CMD_ALU_NOP: begin
                r_state     <= ALU_FUN;
                clk_gate_en <= 1'b1;
              end
              default:    r_state <= IDLE;
            endcase
          end
        end
        WR_ADDR: begin
          if (rx_valid) begin
            r_addr  <= rx_data[ADDR_W-1:0];
            r_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_valid) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= r_addr;
            rf_wr_data <= rx_data;
            r_state    <= IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_valid) begin
            rf_rd_en <= 1'b1;
            rf_addr  <= rx_data[ADDR_W-1:0];
            r_state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rf_rd_valid) begin
            r_result <= ALU_OUT_W'(rf_rd_data);
            r_is_alu <= 1'b0;
            r_state  <= TX_BYTE0;
          end
        end
        ALU_A: begin
          if (rx_valid) begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= ADDR_W'(OPA_ADDR);
            rf_wr_data <= rx_data;
            r_state    <= ALU_B;
          end
        end
        ALU_B: begin
          if (rx_valid) begin
            rf_wr_en    <= 1'b1;
            rf_addr     <= ADDR_W'(OPB_ADDR);
            rf_wr_data  <= rx_data;
            clk_gate_en <= 1'b1;
            r_state     <= ALU_FUN;
          end
        end
        ALU_FUN: begin
          if (rx_valid) begin
            alu_fun <= rx_data[3:0];
            alu_en  <= 1'b1;
            r_state <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          // Gate stays open until the cycle the result is captured.
          if (alu_out_valid) begin
            r_result    <= alu_out;
            r_is_alu    <= 1'b1;
            clk_gate_en <= 1'b0;
            r_state     <= TX_BYTE0;
          end
        end
        TX_BYTE0: begin
          // tx_data updates together with tx_valid so it is stable while full.
          if (!fifo_full) begin
            tx_valid <= 1'b1;
            tx_data  <= r_result[DATA_W-1:0];
            r_state  <= r_is_alu ? TX_BYTE1 : IDLE;
          end
        end
        TX_BYTE1: begin
          if (!fifo_full) begin
            tx_valid <= 1'b1;
            tx_data  <= r_result[2*DATA_W-1:DATA_W];
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - scoreboard bench for alu_cmd_ctrl with directed command frames
module tb_alu_cmd_ctrl;

  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_ALU = 2;
  localparam int EV_TX  = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  logic        clk;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic        clk_gate_en;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        fifo_full;

  ev_t         q[$];
  int          checks;
  int          failures;
  int          tx_seen;
  logic        prev_alu_en;
  logic [15:0] alu_plan;
  logic [7:0]  mem [16];

  alu_cmd_ctrl dut (
    .clk          (clk),
    .RST          (RST),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .alu_out      (alu_out),
    .alu_out_valid(alu_out_valid),
    .alu_fun      (alu_fun),
    .alu_en       (alu_en),
    .clk_gate_en  (clk_gate_en),
    .rf_addr      (rf_addr),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_data   (rf_wr_data),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_data   (rf_rd_data),
    .rf_rd_valid  (rf_rd_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .fifo_full    (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU and register file: one cycle from strobe to valid.
  always @(posedge clk) begin
    alu_out_valid <= alu_en;
    if (alu_en) alu_out <= alu_plan;
    rf_rd_valid <= rf_rd_en;
    rf_rd_data  <= mem[rf_addr];
    if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
  end

  task automatic sb_check(input int kind, input int addr, input int data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d addr=%0h data=%0h, none expected", kind, addr, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.addr != addr || e.data != data) begin
        failures++;
        $display("FAIL event got kind=%0d addr=%0h data=%0h exp kind=%0d addr=%0h data=%0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RST) begin
      if (rf_wr_en) sb_check(EV_WR, int'(rf_addr), int'(rf_wr_data));
      if (rf_rd_en) sb_check(EV_RD, int'(rf_addr), 0);
      if (alu_en) begin
        sb_check(EV_ALU, 0, int'(alu_fun));
        check_bit("gate_at_alu_en", clk_gate_en, 1'b1);
        check_bit("alu_en_width", prev_alu_en, 1'b0);
      end
      if (alu_out_valid) check_bit("gate_at_result", clk_gate_en, 1'b1);
      if (tx_valid) begin
        tx_seen++;
        sb_check(EV_TX, 0, int'(tx_data));
        check_bit("tx_while_full", fifo_full, 1'b0);
        check_bit("gate_off_at_tx", clk_gate_en, 1'b0);
      end
    end
    prev_alu_en = alu_en;
  end

  task automatic push(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d exp=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    logic [35:0] v;
    v = {alu_fun, alu_en, clk_gate_en, rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, tx_data, tx_valid};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL %s outputs=%h exp=0", name, v);
    end
  endtask

  initial begin
    int tx_before;
    checks      = 0;
    failures    = 0;
    tx_seen     = 0;
    prev_alu_en = 1'b0;
    alu_plan    = 16'h0000;
    alu_out     = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    RST       = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    RST = 1'b1;
    @(posedge clk);
    #1;

    push(EV_WR, 5, 8'h3C);
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C); end_frame();
    drain("write");

    push(EV_RD, 5, 0);
    push(EV_TX, 0, 8'h3C);
    send_byte(8'hBB); send_byte(8'h05); end_frame();
    drain("read");

    alu_plan = 16'h0001;
    push(EV_WR, 0, 8'h07);
    push(EV_WR, 1, 8'h07);
    push(EV_ALU, 0, 9);
    push(EV_TX, 0, 8'h01);
    push(EV_TX, 0, 8'h00);
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h07); send_byte(8'h09); end_frame();
    drain("alu_op");

    push(EV_WR, 2, 8'h99);
    send_byte(8'h55); end_frame();
    @(posedge clk);
    #1;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h99); end_frame();
    drain("ignore_55");

    fifo_full = 1'b1;
    alu_plan  = 16'h0002;
    push(EV_ALU, 0, 4'hA);
    push(EV_TX, 0, 8'h02);
    push(EV_TX, 0, 8'h00);
    tx_before = tx_seen;
    send_byte(8'hDD); send_byte(8'h0A); end_frame();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tx_seen != tx_before) begin
      failures++;
      $display("FAIL backpressure_hold tx_strobes=%0d exp=0", tx_seen - tx_before);
    end
    fifo_full = 1'b0;
    drain("backpressure");
    checks++;
    if (tx_seen - tx_before != 2) begin
      failures++;
      $display("FAIL backpressure_count tx_strobes=%0d exp=2", tx_seen - tx_before);
    end

    alu_plan = 16'h1234;
    push(EV_ALU, 0, 3);
    push(EV_TX, 0, 8'h34);
    push(EV_TX, 0, 8'h12);
    send_byte(8'hDD); send_byte(8'h03); send_byte(8'hBB); send_byte(8'h05); end_frame();
    drain("drop_in_wait");

    push(EV_WR, 0, 8'h11);
    send_byte(8'hCC); send_byte(8'h11); end_frame();
    @(posedge clk);
    #1;
    RST = 1'b0;
    #2;
    check_zero("reset_in_alu_b");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    RST = 1'b1;
    @(posedge clk);
    #1;
    push(EV_WR, 3, 8'h5A);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5A); end_frame();
    drain("after_reset");
    check_bit("gate_idle", clk_gate_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer that sits between the UART RX byte stream and the register file, ALU and TX FIFO.
- Decodes framed byte commands: register write, register read, ALU op with operands, ALU op without operands.
- Drives ALU_FUN / enable and the ALU clock-gate enable.
- Captures the 16-bit ALU result or the 8-bit register read data and pushes it to the TX FIFO, honouring FIFO full.

Parameters:
DATA_W, 8, RX/TX byte and register-file data width
ALU_OUT_W, 16, ALU result width (sent LSB byte first)
ADDR_W, 4, register-file address width
OPA_ADDR, 0, register-file address holding operand A
OPB_ADDR, 1, register-file address holding operand B

Ports:
clk  in  1  system clock
RST  in  1  asynchronous active-low reset
rx_data  in  DATA_W  received byte
rx_valid  in  1  single-cycle strobe, rx_data valid
alu_out  in  ALU_OUT_W  ALU result
alu_out_valid  in  1  ALU result-valid flag
alu_fun  out  4  ALU function code
alu_en  out  1  ALU enable, one-cycle pulse
clk_gate_en  out  1  ALU clock-gate enable
rf_addr  out  ADDR_W  register-file address
rf_wr_en  out  1  register-file write strobe
rf_wr_data  out  DATA_W  register-file write data
rf_rd_en  out  1  register-file read strobe
rf_rd_data  in  DATA_W  register-file read data
rf_rd_valid  in  1  read data valid
tx_data  out  DATA_W  byte to TX FIFO
tx_valid  out  1  TX FIFO write strobe
fifo_full  in  1  TX FIFO full

Behaviour:
- Reset: RST is asynchronous and active-low; clock is clk. On reset all outputs are 0, the FSM goes to IDLE and captured registers are cleared. Reset mid-command aborts the frame with no further strobes.
- Commands: byte 1 is accepted in IDLE only, on rx_valid.
  - 0xAA: write. Frame is addr byte, then data byte.
  - 0xBB: read. Frame is addr byte.
  - 0xCC: ALU op with operands. Frame is A byte, B byte, FUN byte.
  - 0xDD: ALU op without operands. Frame is FUN byte.
  - Any other byte in IDLE is ignored and the FSM stays in IDLE.
- Address bytes use their low ADDR_W bits. FUN bytes use their low 4 bits.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_BYTE0, TX_BYTE1.
  - IDLE: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to ALU_A, 0xDD to ALU_FUN.
  - WR_ADDR: on rx_valid, latch the address and go to WR_DATA.
  - WR_DATA: on rx_valid, drive rf_wr_en=1 for one cycle with rf_addr = latched address and rf_wr_data = rx_data, then go to IDLE.
  - RD_ADDR: on rx_valid, drive rf_rd_en=1 for one cycle with rf_addr=rx_data, then go to RD_WAIT.
  - RD_WAIT: on rf_rd_valid, latch rf_rd_data and go to TX_BYTE0. A read produces one TX byte only.
  - ALU_A: on rx_valid, write rx_data to OPA_ADDR (one-cycle rf_wr_en), then go to ALU_B.
  - ALU_B: on rx_valid, write rx_data to OPB_ADDR, then go to ALU_FUN.
  - ALU_FUN: on rx_valid, drive alu_fun and pulse alu_en for one cycle, then go to ALU_WAIT.
  - ALU_WAIT: alu_fun is held. On alu_out_valid, latch alu_out and go to TX_BYTE0. Result latency is 1 cycle after alu_en (registered ALU outputs).
- clk_gate_en is 1 from entry to ALU_FUN until the cycle the result is latched. It is 0 at all other times.
- TX: tx_valid is asserted only when fifo_full=0.
  - If fifo_full=1, the FSM holds in the TX state with tx_valid=0 and tx_data stable.
  - TX_BYTE0 sends the result bits [7:0] (ALU) or the read data (read), then goes to TX_BYTE1 for ALU results or to IDLE for reads.
  - TX_BYTE1 sends bits [15:8] when not full, then goes to IDLE.
- rx_valid arriving in RD_WAIT, ALU_WAIT or any TX state is dropped; no queueing.
- A back-to-back rx_valid in consecutive cycles is accepted, one byte per cycle.
- Every strobe (rf_wr_en, rf_rd_en, alu_en, tx_valid) is registered and exactly one cycle wide per event.

Decomposition:
- Shared package alu_cmd_pkg holds:
  - command opcode constants CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD;
  - the FSM state enum;
  - OPA_ADDR/OPB_ADDR defaults.
- No sub-module is needed; the FSM and output registers live in one module.

Test Plan:
- Write: RX AA,05,3C → one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; no tx_valid.
- Read: RX BB,05; rf_rd_valid returns 0x3C → rf_rd_en with addr 5; one tx_valid with tx_data=0x3C; FSM back in IDLE.
- ALU op: RX CC,07,07,09; ALU model returns 0x0001 one cycle after alu_en → writes to addr 0 and 1; alu_fun=9 with one alu_en pulse; clk_gate_en high through capture; TX bytes 0x01 then 0x00.
- FIFO backpressure: RX DD,0A with result 0x0002 and fifo_full=1 for 5 cycles → no tx_valid while full; then 0x02 and 0x00 are each sent on a single strobe.
- Robustness: RX 55 in IDLE → ignored. RX during ALU_WAIT → dropped. Reset asserted in ALU_B → all outputs 0 and IDLE; a following AA frame works normally.
